vnu_param: RTL and testbench
============================

VNU_PARAM -- requirements
Module: vnu_param

Interface
REQ-001 SHALL provide parameter W, default 8: signed two's-complement message width in bits (W >= 4).
REQ-002 SHALL provide parameter DV, default 3: variable-node degree, i.e. number of check-node inputs (2 <= DV <= 16).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port r_in, input, DV*W: check-to-variable messages R[0..DV-1], with R[i] in bits [i*W +: W], signed.
REQ-006 SHALL have port l_in, input, W: signed channel LLR L.
REQ-007 SHALL have port init, input, 1: when 1 on an accepted beat, the beat is an initialisation beat (R ignored).
REQ-008 SHALL have port in_valid, input, 1: the input beat is valid.
REQ-009 SHALL have port in_ready, output, 1: the block accepts a beat this cycle.
REQ-010 SHALL have port q_out, output, DV*W: variable-to-check messages Q[0..DV-1], packed like r_in, signed.
REQ-011 SHALL have port p_out, output, 1: hard decision, 1 = negative total LLR.
REQ-012 SHALL have port out_valid, output, 1: q_out and p_out are valid.
REQ-013 SHALL have port out_ready, input, 1: the downstream consumer accepts the output.

Function
REQ-014 SHALL define MAX = 2^(W-1)-1 and SW = W + ceil(log2(DV+1)); all internal sums SHALL be sign-extended to SW bits, so no intermediate overflow occurs.
REQ-015 SHALL compute, for a normal beat, TOTAL = L + sum of R[i] over i = 0..DV-1, and Q[i] = sat(TOTAL - R[i]).
REQ-016 SHALL define sat(x) as the symmetric clamp to [-MAX, +MAX]; the code -2^(W-1) SHALL never appear on q_out.
REQ-017 SHALL set, for an init beat, every Q[i] = sat(L) and TOTAL = L.
REQ-018 SHALL set p_out = 1 iff the full-width TOTAL < 0, evaluated before saturation; TOTAL = 0 gives p_out = 0.
REQ-019 SHALL use a two-stage pipeline: stage A registers TOTAL, the R copies and the init flag; stage B registers q_out, p_out and out_valid.
REQ-020 SHALL advance both stages together on a global enable en = !out_valid || out_ready.
REQ-021 SHALL drive in_ready = en, which is combinational from out_ready and out_valid.
REQ-022 SHALL accept a beat on a cycle where in_valid && in_ready; the stage-A valid bit SHALL then be loaded with in_valid whenever en = 1.
REQ-023 SHALL, with no stall, present the result of a beat accepted in cycle N in cycle N+2 (out_valid = 1), with throughput of one beat per cycle.
REQ-024 SHALL, while out_valid && !out_ready, hold q_out, p_out, out_valid and stage A stable, and deassert in_ready.
REQ-025 SHALL complete an output transfer on out_valid && out_ready; if stage A holds no valid beat in that cycle, out_valid SHALL fall the next cycle.
REQ-026 SHALL allow simultaneous input accept and output transfer in the same cycle without loss or duplication.
REQ-027 SHALL not squeeze bubbles: an empty stage A propagates as out_valid = 0 through stage B.
REQ-028 SHALL pass input values of -2^(W-1) on r_in or l_in into the sum unclamped; only the outputs are saturated.

Reset
REQ-029 SHALL, while rst = 0, clear asynchronously the stage-A valid bit, out_valid, q_out (all zeros), p_out (0) and all stage-A data registers.
REQ-030 SHALL discard any in-flight beat when reset is asserted mid-operation; no output for that beat appears after reset is released.
REQ-031 SHALL drive in_ready = 1 during and immediately after reset, because out_valid = 0.
REQ-032 SHALL make its first accept possible on the first rising clk edge after rst rises.

Verification
REQ-033 SHALL cover the basic case: W=8, DV=3, R=(10,20,-5), L=7, init=0, out_ready=1 -> two cycles later Q=(22,12,37), p_out=0.
REQ-034 SHALL cover saturation: R=(100,100,100), L=100 -> Q=(127,127,127), p_out=0; and R=(-100,-100,-100), L=-100 -> Q=(-127,-127,-127), p_out=1.
REQ-035 SHALL cover the init beat: init=1, L=-128, R arbitrary -> Q=(-127,-127,-127), p_out=1.
REQ-036 SHALL cover the zero total: R=(5,-3,-9), L=7 -> TOTAL=0, Q=(-5,3,9), p_out=0.
REQ-037 SHALL cover backpressure: issue 4 back-to-back beats with out_ready=0 for 5 cycles, then 1 -> in_ready=0 while stalled, outputs held, all 4 results delivered in order exactly once.
REQ-038 SHALL cover reset mid-flight: assert rst=0 one cycle after an accept -> out_valid=0, q_out=0, p_out=0 immediately, and no stale output after rst=1.

Source files
------------

// File: rtl/vnu_param.sv
// vnu_param: LDPC variable-node update, two-stage valid/ready pipeline.
// Stage A registers TOTAL = L + sum(R), the R copies and the init flag.
// Stage B registers Q[i] = sat(TOTAL - R[i]), the hard decision and out_valid.
//
// Ports:
//   clk, rst (async active-low)
//   r_in   [DV*W] check-to-variable messages, R[i] at [i*W +: W], signed
//   l_in   [W]    channel LLR, signed
//   init          initialisation beat: every Q[i] = sat(L), R ignored
//   in_valid / in_ready    input handshake
//   q_out  [DV*W] variable-to-check messages, packed like r_in, signed
//   p_out         hard decision, 1 = negative total
//   out_valid / out_ready  output handshake
module vnu_param #(
   parameter int W  = 8,
   parameter int DV = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DV*W-1:0] r_in,
   input  logic [W-1:0]    l_in,
   input  logic            init,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [DV*W-1:0] q_out,
   output logic            p_out,
   output logic            out_valid,
   input  logic            out_ready
);

   localparam int LG = $clog2(DV + 1);
   localparam int SW = W + LG;

   localparam logic signed [SW-1:0] MAXV =
      SW'((1 << (W - 1)) - 1);
   localparam logic signed [SW-1:0] MINV = -MAXV;

   function automatic logic signed [SW-1:0] sext(
      input logic [W-1:0] v
   );
      return {{LG{v[W-1]}}, v};
   endfunction

   // Symmetric clamp: -2^(W-1) is never produced.
   function automatic logic [W-1:0] sat(
      input logic signed [SW-1:0] x
   );
      if (x > MAXV)
         return MAXV[W-1:0];
      else if (x < MINV)
         return MINV[W-1:0];
      else
         return x[W-1:0];
   endfunction

   logic                   en;
   logic                   acc;
   logic signed [SW-1:0]   sum_in;

   logic                   a_vld_q, a_vld_d;
   logic signed [SW-1:0]   a_tot_q, a_tot_d;
   logic [DV*W-1:0]        a_r_q, a_r_d;
   logic                   a_init_q, a_init_d;

   logic [DV*W-1:0]        q_q, q_d;
   logic                   p_q, p_d;
   logic                   ov_q, ov_d;

   always_comb begin
      // Both stages move together; a stalled output freezes everything.
      en  = !ov_q || out_ready;
      acc = in_valid && en;

      sum_in = sext(l_in);
      for (int i = 0; i < DV; i++)
         sum_in = sum_in + sext(r_in[i*W +: W]);

      a_vld_d  = en ? in_valid : a_vld_q;
      a_tot_d  = a_tot_q;
      a_r_d    = a_r_q;
      a_init_d = a_init_q;
      if (acc) begin
         a_tot_d  = init ? sext(l_in) : sum_in;
         a_r_d    = r_in;
         a_init_d = init;
      end

      // Bubbles in stage A become out_valid = 0.
      ov_d = en ? a_vld_q : ov_q;
      q_d  = q_q;
      p_d  = p_q;
      if (en && a_vld_q) begin
         p_d = a_tot_q[SW-1];
         for (int i = 0; i < DV; i++) begin
            if (a_init_q)
               q_d[i*W +: W] = sat(a_tot_q);
            else
               q_d[i*W +: W] =
                  sat(a_tot_q - sext(a_r_q[i*W +: W]));
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_vld_q  <= 1'b0;
         a_tot_q  <= '0;
         a_r_q    <= '0;
         a_init_q <= 1'b0;
         q_q      <= '0;
         p_q      <= 1'b0;
         ov_q     <= 1'b0;
      end else begin
         a_vld_q  <= a_vld_d;
         a_tot_q  <= a_tot_d;
         a_r_q    <= a_r_d;
         a_init_q <= a_init_d;
         q_q      <= q_d;
         p_q      <= p_d;
         ov_q     <= ov_d;
      end
   end

   assign in_ready  = en;
   assign q_out     = q_q;
   assign p_out     = p_q;
   assign out_valid = ov_q;

endmodule

// File: tb/tb_vnu_param.sv
// tb_vnu_param: scoreboard bench for vnu_param (W=8, DV=3).
// Directed vectors with hand-computed results; a monitor pops and compares.
module tb_vnu_param;

   localparam int W  = 8;
   localparam int DV = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [DV*W-1:0] r_in = '0;
   logic [W-1:0]    l_in = '0;
   logic            init = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [DV*W-1:0] q_out;
   logic            p_out;
   logic            out_valid;
   logic            out_ready = 1'b1;

   typedef struct {
      logic [DV*W-1:0] q;
      logic            p;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;

   vnu_param #(.W(W), .DV(DV)) dut (
      .clk       (clk),
      .rst       (rst),
      .r_in      (r_in),
      .l_in      (l_in),
      .init      (init),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q_out     (q_out),
      .p_out     (p_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] pack3(input int a, input int b,
                                         input int c);
      return {c[7:0], b[7:0], a[7:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   // Call just after a rising edge; returns just after the accepting edge.
   task automatic send(input int r0, input int r1, input int r2,
                       input int l, input logic ini,
                       input int q0, input int q1, input int q2,
                       input logic p);
      exp_t e;
      int   n;
      r_in     = pack3(r0, r1, r2);
      l_in     = l[7:0];
      init     = ini;
      in_valid = 1'b1;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout got=0 want=1");
      end else begin
         e.q = pack3(q0, q1, q2);
         e.p = p;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      init     = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout left=%0d want=0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output got=%0h want=none",
                     q_out);
         end else begin
            mon_e = sb.pop_front();
            chk("q_out", q_out, mon_e.q);
            chk("p_out", p_out, mon_e.p);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_q_out", q_out, 0);
      chk("rst_p_out", p_out, 0);
      chk("rst_in_ready", in_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      // Basic vector, also checks the two-cycle latency.
      send(10, 20, -5, 7, 0, 22, 12, 37, 0);
      chk("lat_n1", out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_n2", out_valid, 1);
      drain();

      // Back-to-back directed vectors.
      send(100, 100, 100, 100, 0, 127, 127, 127, 0);
      send(-100, -100, -100, -100, 0, -127, -127, -127, 1);
      send(55, -3, 1, -128, 1, -127, -127, -127, 1);
      send(5, -3, -9, 7, 0, -5, 3, 9, 0);
      send(-128, -128, -128, -128, 0, -127, -127, -127, 1);
      send(-128, 0, 0, 0, 0, 0, -127, -127, 1);
      drain();

      // Backpressure: four beats, output stalled for five cycles.
      out_ready = 1'b0;
      fork
         begin
            send(1, 2, 3, 4, 0, 9, 8, 7, 0);
            send(-1, -2, -3, -4, 0, -9, -8, -7, 1);
            send(50, -50, 0, 0, 0, -50, 50, 0, 0);
            send(0, 0, 0, 100, 1, 100, 100, 100, 0);
         end
         begin
            repeat (5) begin
               @(negedge clk);
               if (out_valid) begin
                  chk("stall_in_ready", in_ready, 0);
                  chk("stall_q_hold", q_out, pack3(9, 8, 7));
                  chk("stall_p_hold", p_out, 0);
               end
            end
            chk("stall_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset one cycle after an accept discards the beat.
      send(10, 20, -5, 7, 0, 22, 12, 37, 0);
      rst = 1'b0;
      #1;
      sb.delete();
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_q_out", q_out, 0);
      chk("mid_rst_p_out", p_out, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("no_stale_out", out_valid, 0);

      send(5, -3, -9, 7, 0, -5, 3, 9, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
